// File: rtl/sub_seq_64bit_pkg.sv
// Shared definitions for the word-serial subtractor: FSM encoding and
// slice-count / index-width derivations.
package sub_seq_64bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sub_seq_64bit_slice.sv
// Combinational SLICE-bit ripple adder: s = x + y + cin, cout = carry out.
// The caller supplies the already-inverted subtrahend as y.
module sub_slice
  import sub_seq_64bit_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/sub_seq_64bit.sv
// Word-serial subtractor diff = a - b - bin, one SLICE-bit slice per cycle,
// LSB first. Define SUB_SEQ_64BIT_SAT_EN to saturate diff on signed overflow.
module sub_seq_64bit
  import sub_seq_64bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IDX_W  = calc_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("sub_seq_64bit: WIDTH must be a multiple of SLICE");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q, raw_diff, res_diff;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, bout_q, ovf_q, zero_q;
  logic             accept, last, ovf_raw;
  logic [SLICE-1:0] slice_x, slice_y, slice_s;
  logic             slice_cout;

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (state_q == RUN) && (idx_q == LAST_IDX);

  // Single shared slice, steered by the index register
  assign slice_x = a_q[idx_q*SLICE +: SLICE];
  assign slice_y = ~b_q[idx_q*SLICE +: SLICE];

  sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .x   (slice_x),
    .y   (slice_y),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  // Full raw difference as it will look once the current slice is written;
  // on the last slice this lets ovf/zero/saturation resolve on the same edge.
  always_comb begin
    raw_diff = diff_q;
    raw_diff[idx_q*SLICE +: SLICE] = slice_s;
  end

  assign ovf_raw = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_diff[WIDTH-1] != a_q[WIDTH-1]);

`ifdef SUB_SEQ_64BIT_SAT_EN
  always_comb begin
    res_diff = raw_diff;
    if (ovf_raw)
      res_diff = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_diff = raw_diff;
`endif

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= ~bin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      carry_q <= slice_cout;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        diff_q <= res_diff;
        bout_q <= ~slice_cout;
        ovf_q  <= ovf_raw;
        zero_q <= (res_diff == '0);
      end else begin
        diff_q[idx_q*SLICE +: SLICE] <= slice_s;
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_sub_seq_64bit.sv
// Self-checking bench for sub_seq_64bit: vector table plus random vectors
// through a scoreboard, and hand-written hold / mid-run reset sequences.
module tb_sub_seq_64bit;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        bout, ovf, zero;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  vec_t tbl[8];
  vec_t sb[$];

  sub_seq_64bit #(
    .WIDTH(64),
    .SLICE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Independent 65-bit reference for a - b - bin
  function automatic vec_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
    vec_t r;
    logic [64:0] t;
    t = {1'b0, x} - {1'b0, y} - {64'd0, bi};
    r.a = x; r.b = y; r.bin = bi;
    r.d  = t[63:0];
    r.bo = t[64];
    r.ov = (x[63] != y[63]) && (r.d[63] != x[63]);
`ifdef SUB_SEQ_64BIT_SAT_EN
    if (r.ov) r.d = x[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    r.z = (r.d == 64'd0);
    return r;
  endfunction

  task automatic wait_ready(input string name);
    int unsigned n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_in_ready_wait"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic compare_out(input string name);
    vec_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_diff"}, diff, e.d);
    chk({name, "_bout"}, {63'd0, bout}, {63'd0, e.bo});
    chk({name, "_ovf"},  {63'd0, ovf},  {63'd0, e.ov});
    chk({name, "_zero"}, {63'd0, zero}, {63'd0, e.z});
  endtask

  // One operation; hold > 0 keeps out_ready low that many cycles while
  // offering fresh operands that must be ignored.
  task automatic do_op(input string name, input vec_t v, input int unsigned hold);
    int unsigned lat;
    logic [63:0] d_snap;
    wait_ready(name);
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; bin = ~v.bin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd4);
    if (hold > 0) begin
      d_snap = diff;
      for (int unsigned i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        @(negedge clk);
        chk({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({name, "_hold_diff"}, diff, d_snap);
      end
      in_valid = 1'b0;
    end
    compare_out(name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_in_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    vec_t v;
    int unsigned n;

    tbl[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
`ifdef SUB_SEQ_64BIT_SAT_EN
    tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
`else
    tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
`endif
    tbl[4] = '{64'h0000_0001_0000_0000, 64'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000, 1'b0, 64'h0000_FFFF_FFFF_0000, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    foreach (tbl[i]) do_op($sformatf("tbl%0d", i), tbl[i], 0);

    for (int unsigned i = 0; i < 6; i++) begin
      v = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      do_op($sformatf("rnd%0d", i), v, 0);
    end

    // Output back-pressure with ignored operands
    do_op("hold", model(64'd5, 64'd3, 1'b0), 10);

    // Reset two cycles into RUN
    wait_ready("mid_rst");
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_diff", diff, 64'd0);
    chk("mid_rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_after", {63'd0, in_ready}, 64'd1);
    n = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("mid_rst_no_valid", 64'(n), 64'd0);

    do_op("after_rst", '{64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1}, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sub_seq_64bit.md
Name: sub_seq_64bit

Overview:
- Multi-cycle, word-serial two's-complement subtractor: diff = a - b - bin.
- Inverse-direction companion to the team's ripple adder chain.
- Reuses a single SLICE-bit ripple slice over WIDTH/SLICE cycles, LSB slice first, with a registered carry/borrow between slices.
- Sits on datapath buses behind valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SLICE, 16, bits processed per cycle. WIDTH % SLICE != 0 is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- diff  output  WIDTH  difference.
- bout  output  1  unsigned borrow out.
- ovf  output  1  signed overflow.
- zero  output  1  diff == 0.

Behaviour:
- Arithmetic: diff = a + ~b + ~bin, with carry ripple across slices.
  - bout = ~final_carry, i.e. 1 when a < b + bin (unsigned).
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed on the raw difference.
  - zero is evaluated on the final, post-feature diff.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b; set carry = ~bin; idx = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle computes slice idx, writes diff[idx*SLICE +: SLICE], registers the carry, and increments idx.
  - At idx == NSLICE-1, go to DONE.
- DONE:
  - out_valid=1; diff, bout, ovf and zero are held stable.
  - On out_ready: go to IDLE. in_ready rises the next cycle.
- Latency: out_valid rises NSLICE edges after the accept edge (4 with defaults).
  - Throughput: one operation per NSLICE+2 cycles.
  - An operation may not be accepted in the same cycle as out_ready.
- in_valid while in RUN or DONE is ignored; operands are not latched.
- Internal operand registers are fixed at accept. Input changes after accept have no effect.
- Reset (any state, including mid-RUN):
  - State returns to IDLE; idx=0; carry=0.
  - out_valid=0, diff=0, bout=0, ovf=0, zero=0.
  - in_ready=0 during the reset cycle and 1 on the first cycle after it.
- The result is discarded on reset; no partial output is ever flagged valid.

Optional Feature:
- Macro: SUB_SEQ_64BIT_SAT_EN.
- Defined: when ovf=1, diff saturates.
  - a[MSB]=1 gives signed minimum (1 followed by zeros).
  - a[MSB]=0 gives signed maximum (0 followed by ones).
  - The substitution is applied on the DONE-entry edge. ovf is still reported as 1; bout is unaffected.
- Undefined: the wrapped two's-complement diff is presented.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the NSLICE = WIDTH/SLICE derivation;
  - the index width constant clog2(NSLICE).
- One sub-module: sub_slice, a combinational SLICE-bit ripple adder taking (x, ~y, cin) and producing (s, cout). It is instantiated once and sequenced by the control FSM in sub_seq_64bit.

Test Plan:
1. a=5, b=3, bin=0 -> diff=2, bout=0, ovf=0, zero=0. out_valid exactly 4 edges after the accept edge.
2. a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
3. a=0x8000_0000_0000_0000, b=1, bin=0 -> ovf=1, bout=0.
   - Without the macro: diff=0x7FFF_FFFF_FFFF_FFFF.
   - With SUB_SEQ_64BIT_SAT_EN: diff=0x8000_0000_0000_0000.
4. a=0x0000_0001_0000_0000, b=1, bin=1 (cross-slice borrow chain) -> diff=0x0000_0000_FFFF_FFFE, bout=0, ovf=0.
5. Hold out_ready=0 for 10 cycles after out_valid, while driving in_valid=1 with new operands.
   - Required: outputs stable, in_ready=0, new operands not taken.
   - Then out_ready=1: out_valid=0 and in_ready=1 the next cycle.
6. Assert rst after 2 RUN cycles.
   - Required: all outputs 0 and out_valid never asserted for that op.
   - Next op a=7, b=7, bin=0 -> diff=0, zero=1, bout=0.
